// File: rtl/scan_sequencer_pkg.sv
// Shared definitions for the channel scan sequencer: state encoding and
// default select/counter widths.
package scan_sequencer_pkg;

    localparam int SEL_W_DEF = 3;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BLANK  = 2'd2
    } state_t;

endpackage

// File: rtl/scan_sequencer_next_channel.sv
// Round-robin priority finder: lowest set mask bit above the current index,
// else the lowest set bit overall (a wrap). i_from_start treats the current
// index as "before 0" so the first set bit is chosen without a wrap.
module next_channel #(
    parameter int SEL_W = 3
) (
    input  logic [2**SEL_W-1:0] i_mask,
    input  logic [SEL_W-1:0]    i_cur,
    input  logic                i_from_start,
    output logic [SEL_W-1:0]    o_next,
    output logic                o_wrap,
    output logic                o_none
);

    localparam int NCH = 2**SEL_W;

    logic [SEL_W-1:0] w_hi;
    logic [SEL_W-1:0] w_lo;
    logic             w_hi_found;

    // Scan downwards so the last hit written is the lowest qualifying index.
    always_comb begin
        w_hi       = '0;
        w_lo       = '0;
        w_hi_found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                w_lo = SEL_W'(i);
                if (i_from_start || (SEL_W'(i) > i_cur)) begin
                    w_hi       = SEL_W'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
    end

    assign o_none = (i_mask == '0);
    assign o_next = w_hi_found ? w_hi : w_lo;
    assign o_wrap = !w_hi_found && !o_none;

endmodule

// File: rtl/scan_sequencer.sv
// Round-robin channel scanner driving a downstream enabled decoder: each
// masked channel is enabled for a dwell time, optionally followed by a gap.
module scan_sequencer
    import scan_sequencer_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Start,
    input  logic                Stop,
    input  logic [2**SEL_W-1:0] Mask,
    input  logic [CNT_W-1:0]    Dwell,
    input  logic [CNT_W-1:0]    Blank,
    output logic [SEL_W-1:0]    w,
    output logic                En,
    output logic                Busy,
    output logic                Wrap
);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [SEL_W-1:0] r_w, w_w_nxt;
    logic             r_en, w_en_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_wrap, w_wrap_nxt;

    logic [SEL_W-1:0] w_nc_next;
    logic             w_nc_wrap;
    logic             w_nc_none;
    logic             w_adv;
    logic [CNT_W-1:0] w_dwell_m1;

    assign w_dwell_m1 = (Dwell == '0) ? '0 : Dwell - CNT_W'(1);

    next_channel #(.SEL_W(SEL_W)) u_next (
        .i_mask       (Mask),
        .i_cur        (r_w),
        .i_from_start (r_state == ST_IDLE),
        .o_next       (w_nc_next),
        .o_wrap       (w_nc_wrap),
        .o_none       (w_nc_none)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_w_nxt     = r_w;
        w_en_nxt    = r_en;
        w_busy_nxt  = r_busy;
        w_wrap_nxt  = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_en_nxt   = 1'b0;
                w_busy_nxt = 1'b0;
                if (Start && !w_nc_none) begin
                    w_state_nxt = ST_ACTIVE;
                    w_w_nxt     = w_nc_next;
                    w_cnt_nxt   = w_dwell_m1;
                    w_en_nxt    = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (Blank == '0) begin
                    w_adv = 1'b1;
                end else begin
                    w_cnt_nxt   = Blank - CNT_W'(1);
                    w_state_nxt = ST_BLANK;
                    w_en_nxt    = 1'b0;
                end
            end
            ST_BLANK: begin
                if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
                else             w_adv     = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Mask is only looked at here; an empty mask ends the scan.
        if (w_adv) begin
            if (w_nc_none) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_en_nxt    = 1'b0;
                w_busy_nxt  = 1'b0;
            end else begin
                w_state_nxt = ST_ACTIVE;
                w_w_nxt     = w_nc_next;
                w_wrap_nxt  = w_nc_wrap;
                w_cnt_nxt   = w_dwell_m1;
                w_en_nxt    = 1'b1;
            end
        end
        if (Stop) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_w_nxt     = r_w;
            w_en_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
            w_wrap_nxt  = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_cnt  <= '0;
            r_w    <= '0;
            r_en   <= 1'b0;
            r_busy <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_w    <= w_w_nxt;
            r_en   <= w_en_nxt;
            r_busy <= w_busy_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign w    = r_w;
    assign En   = r_en;
    assign Busy = r_busy;
    assign Wrap = r_wrap;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: per-cycle vector tables with a
// scoreboard queue, plus hand-written Stop/empty-mask/async-reset sequences.
module tb_scan_sequencer;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Start, Stop;
    logic [7:0]  Mask;
    logic [15:0] Dwell, Blank;
    logic [2:0]  w;
    logic        En, Busy, Wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        start;
        logic        stop;
        logic [7:0]  mask;
        logic [15:0] dwell;
        logic [15:0] blank;
        logic [2:0]  ew;
        logic        een;
        logic        ebusy;
        logic        ewrap;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];

    scan_sequencer dut (
        .Clock (Clock), .Resetn (Resetn), .Start (Start), .Stop (Stop),
        .Mask (Mask), .Dwell (Dwell), .Blank (Blank),
        .w (w), .En (En), .Busy (Busy), .Wrap (Wrap)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic vec_t mk(logic st, logic sp, logic [7:0] m, logic [15:0] d,
                                logic [15:0] b, logic [2:0] ew, logic een,
                                logic eb, logic ewr);
        vec_t v;
        v.start = st; v.stop = sp; v.mask = m; v.dwell = d; v.blank = b;
        v.ew = ew; v.een = een; v.ebusy = eb; v.ewrap = ewr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input vec_t e);
        chk({nm, ".w"}, 16'(w), 16'(e.ew));
        chk({nm, ".En"}, 16'(En), 16'(e.een));
        chk({nm, ".Busy"}, 16'(Busy), 16'(e.ebusy));
        chk({nm, ".Wrap"}, 16'(Wrap), 16'(e.ewrap));
    endtask

    // Drive one cycle of inputs, then compare the registered response.
    task automatic apply(input vec_t v, input string nm);
        vec_t e;
        @(negedge Clock);
        Start = v.start; Stop = v.stop; Mask = v.mask; Dwell = v.dwell; Blank = v.blank;
        exp_q.push_back(v);
        @(posedge Clock);
        #1;
        e = exp_q.pop_front();
        chk_out(nm, e);
    endtask

    task automatic run_tbl(input string nm);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("%s[%0d]", nm, i));
        tbl.delete();
    endtask

    // Mask 00100101, Dwell 3, Blank 1: expected w/En for cycles 1..13.
    task automatic load_basic(input int n);
        logic [2:0] tw [13] = '{0, 0, 0, 0, 2, 2, 2, 2, 5, 5, 5, 5, 0};
        logic       te [13] = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 1};
        for (int i = 0; i < n; i++)
            tbl.push_back(mk(i == 0, 0, 8'b00100101, 16'd3, 16'd1, tw[i], te[i], 1, i == 12));
    endtask

    initial begin
        vec_t e;
        Resetn = 1'b0; Start = 0; Stop = 0; Mask = 0; Dwell = 0; Blank = 0;
        #12;
        e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_out("reset", e);
        @(negedge Clock);
        Resetn = 1'b1;

        // Basic mask with blanking gap and wrap back to channel 0.
        load_basic(13);
        tbl.push_back(mk(0, 1, 8'b00100101, 3, 1, 0, 0, 0, 0));
        run_tbl("basic");

        // Single channel, Dwell 0: every advance is a wrap.
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(i == 0, 0, 8'h80, 0, 0, 3'd7, 1, 1, i >= 1));
        tbl.push_back(mk(0, 1, 8'h80, 0, 0, 3'd7, 0, 0, 0));
        run_tbl("single");

        // Full mask, Dwell 2, no gap: 0,0,1,1,...,7,7,0.
        for (int i = 0; i < 18; i++)
            tbl.push_back(mk(i == 0, 0, 8'hFF, 2, 0, 3'((i / 2) % 8), 1, 1, i == 16));
        tbl.push_back(mk(0, 1, 8'hFF, 2, 0, 3'd0, 0, 0, 0));
        run_tbl("full");

        // Start and Stop together mid-scan on w=3: Stop wins, no restart.
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(i == 0, 0, 8'hFF, 2, 0, 3'((i / 2) % 8), 1, 1, 0));
        tbl.push_back(mk(1, 1, 8'hFF, 2, 0, 3'd3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'hFF, 2, 0, 3'd3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'hFF, 2, 0, 3'd3, 0, 0, 0));
        run_tbl("stopstart");

        // Mask emptied during w=1: scan ends at the next advance; Start with empty mask ignored.
        tbl.push_back(mk(1, 0, 8'h0F, 2, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h0F, 2, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h0F, 2, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h0F, 2, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 2, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 2, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 2, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 2, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 2, 1, 1, 0, 0, 0));
        run_tbl("maskoff");

        // Asynchronous reset between edges while blanking after channel 2.
        load_basic(8);
        run_tbl("prereset");
        #2;
        Resetn = 1'b0;
        #1;
        e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_out("async_reset", e);
        @(negedge Clock);
        Resetn = 1'b1;
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 0, 8'b00100101, 3, 1, 0, 0, 0, 0));
        run_tbl("postreset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

Sequential channel scanner that drives the select (`w`) and enable (`En`) inputs of the team's 3-to-8 enabled decoder, which sits directly downstream. It steps round-robin through the channels enabled in a mask. Each channel is held active for a programmable dwell time, with an optional programmable blanking gap between channels during which `En` is low. It is the upstream control stage for multiplexed display and row-scan paths.

## Interface
- `SEL_W`, 3: select width; channel count is 2**SEL_W (8).
- `CNT_W`, 16: width of the dwell and blank counters.

- `Clock`  in  1: rising-edge clock.
- `Resetn`  in  1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `Start`  in  1: begin scanning; level-sampled in IDLE.
- `Stop`  in  1: abort scanning; honoured in any state.
- `Mask`  in  2**SEL_W: channel enables; bit i set means channel i is scanned.
- `Dwell`  in  CNT_W: active cycles per channel; 0 is treated as 1.
- `Blank`  in  CNT_W: En-low cycles between channels; 0 means no gap.
- `w`  out  SEL_W: current channel index; drives the decoder select.
- `En`  out  1: decoder enable.
- `Busy`  out  1: high in ACTIVE and BLANK.
- `Wrap`  out  1: one-cycle pulse on the first ACTIVE cycle of a channel reached by wrap-around.

## Operation
- Reset values: `w`=0, `En`=0, `Busy`=0, `Wrap`=0, state IDLE, counter 0.
- States: IDLE, ACTIVE, BLANK.
- **Next channel** is the lowest set `Mask` index strictly greater than `w`. If none exists, it is the lowest set index overall, and that move counts as a wrap. With a single-bit mask, every advance is a wrap.
- **IDLE:** `En`=0 and `w` holds its last value.
  - `Start`=1 and `Mask`!=0: load `w` with the lowest set index, load the counter with max(`Dwell`,1)-1, and go to ACTIVE.
  - `Start`=1 and `Mask`=0: ignored.
- **ACTIVE:** `En`=1 and the counter decrements each cycle. When the counter reaches 0:
  - `Blank`=0: advance `w`, reload the dwell count, and stay in ACTIVE. The gap-free handoff is intentional.
  - `Blank`!=0: load the counter with `Blank`-1, go to BLANK, and hold `w`.
- **BLANK:** `En`=0 and the counter decrements. At 0, advance `w`, reload the dwell count, and go to ACTIVE.
- **Sampling:**
  - `Mask` is sampled only at an advance. If it is 0 at that point, go to IDLE.
  - `Dwell` and `Blank` are sampled only at each counter reload.
- **Priority:**
  - `Stop`=1 in any state forces IDLE on the next edge: `En`=0, `Busy`=0, `w` held.
  - `Stop` beats `Start` when both are asserted in the same cycle.
  - `Start` is ignored while `Busy`.
- `Resetn` low mid-scan forces the reset values immediately, without waiting for a clock edge.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `Start` sampled at edge k gives `En`=1 and a valid `w` from cycle k+1.
- Each channel sees exactly max(`Dwell`,1) cycles with `En`=1, then `Blank` cycles with `En`=0.
- Scan period = N × (max(`Dwell`,1) + `Blank`), where N = popcount(`Mask`).
- `w` changes only on a BLANK→ACTIVE or ACTIVE→ACTIVE advance, never while `En` is high within one channel's dwell.
- `Wrap` is high for exactly the first cycle of the wrapped channel. It is never asserted on the initial channel after `Start`.
- `Stop` at edge k gives `En`=0 in cycle k+1.

## Structure
- **Shared package:** state encoding constants (IDLE/ACTIVE/BLANK), plus the `SEL_W` and `CNT_W` defaults.
- **Sub-module `next_channel`:** combinational. Inputs are `Mask` and current `w`; outputs are the next index, a `wrap` flag and a `none` flag (mask empty). It is a priority finder, reused by the IDLE start path with `w` forced to "before 0".
- **Top level:** the state register, one shared down-counter, and the output registers.

## Test plan
- Reset, then `Mask`=8'b00100101, `Dwell`=3, `Blank`=1, `Start` at cycle 0. Required response:
  - `En`=1 with `w`=0 in cycles 1–3.
  - `En`=0 in cycle 4.
  - `w`=2 in cycles 5–7.
  - `w`=5 in cycles 9–11.
  - `w`=0 with `Wrap`=1 in cycle 13.
- `Mask`=8'b10000000, `Dwell`=0, `Blank`=0, `Start` → `w`=7 and `En`=1 continuously; `Wrap` pulses every cycle from cycle 2 onward.
- `Mask`=8'hFF, `Dwell`=2, `Blank`=0 → `w` steps 0,0,1,1,…,7,7,0 with `En` never low, and `Wrap` at the return to 0.
- Mid-scan on `w`=3, with `Start` and `Stop` both asserted → `En`=0 and `Busy`=0 the next cycle, `w` holds 3, and no restart occurs.
- `Mask` changed from 8'h0F to 8'h00 during `w`=1 → at that advance the state goes to IDLE with `En`=0. `Start` with `Mask`=0 leaves `Busy`=0.
- `Resetn` pulled low between clock edges during BLANK → `w`=0, `En`=0, `Busy`=0, `Wrap`=0 immediately, and the block stays in IDLE after `Resetn` rises.
